// File: rtl/parking_pkg.sv
// Shared types and sensor encoding for the parking lane monitor.
// Sensors are active-low; lane FSM states are one-hot.
package parking_pkg;

    typedef enum logic [6:0] {
        IDLE = 7'b000_0001,
        EN1  = 7'b000_0010,
        EN2  = 7'b000_0100,
        EN3  = 7'b000_1000,
        EX1  = 7'b001_0000,
        EX2  = 7'b010_0000,
        EX3  = 7'b100_0000
    } lane_state_t;

    localparam logic BLOCKED = 1'b0;
    localparam logic CLEAR   = 1'b1;

endpackage

// File: rtl/lane_detector.sv
// One gate: sensor synchronisers, debounce, entry/exit sequence FSM and
// per-state timeout. Emits registered one-cycle event pulses.
module lane_detector
    import parking_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic sd1,
    input  logic sd2,
    output logic enter_pulse,
    output logic exit_pulse,
    output logic abort_pulse
);

    localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TW  = $clog2(TIMEOUT);

    logic [1:0]     raw, sync_p0, sync_p1, acc;
    logic [DBW-1:0] db_cnt [2];

    assign raw = {sd2, sd1};

    // Stage p0/p1: two-flop synchroniser, then debounce into accepted level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= {2{CLEAR}};
            sync_p1 <= {2{CLEAR}};
            acc     <= {2{CLEAR}};
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DEBOUNCE - 1)) begin
                    acc[i]    <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    lane_state_t   state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          enter_nx, exit_nx, abort_nx;
    logic          b1, b2;

    assign b1 = (acc[0] == BLOCKED);
    assign b2 = (acc[1] == BLOCKED);

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        enter_nx = 1'b0;
        exit_nx  = 1'b0;
        abort_nx = 1'b0;
        case (state)
            IDLE: if (b1 && !b2) state_nx = EN1;
                  else if (!b1 && b2) state_nx = EX1;
            EN1:  if (b1 && b2) state_nx = EN2;
                  else if (!b1 && !b2) state_nx = IDLE;
            EN2:  if (!b1 && b2) state_nx = EN3;
                  else if (b1 && !b2) state_nx = EN1;
            EN3:  if (!b1 && !b2) begin
                      state_nx = IDLE;
                      enter_nx = 1'b1;
                  end else if (b1 && b2) state_nx = EN2;
            EX1:  if (b1 && b2) state_nx = EX2;
                  else if (!b1 && !b2) state_nx = IDLE;
            EX2:  if (b1 && !b2) state_nx = EX3;
                  else if (!b1 && b2) state_nx = EX1;
            EX3:  if (!b1 && !b2) begin
                      state_nx = IDLE;
                      exit_nx  = 1'b1;
                  end else if (b1 && b2) state_nx = EX2;
            default: state_nx = IDLE;
        endcase
        // A genuine transition wins over a timeout landing on the same cycle
        if (state_nx != state) begin
            timer_nx = '0;
        end else if (state != IDLE) begin
            if (timer == TW'(TIMEOUT - 1)) begin
                state_nx = IDLE;
                abort_nx = 1'b1;
                timer_nx = '0;
            end else begin
                timer_nx = timer + 1'b1;
            end
        end
    end

    // Stage p2: FSM state and registered event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            enter_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            abort_pulse <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            enter_pulse <= enter_nx;
            exit_pulse  <= exit_nx;
            abort_pulse <= abort_nx;
        end
    end

endmodule

// File: rtl/parking_lane_monitor.sv
// Multi-lane car park monitor: LANES gate detectors feeding a shared
// saturating occupancy counter with full/empty and sticky error flags.
module parking_lane_monitor
    import parking_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int CAPACITY = 64,
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES-1:0]              sd1,
    input  logic [LANES-1:0]              sd2,
    output logic [LANES-1:0]              enter_pulse,
    output logic [LANES-1:0]              exit_pulse,
    output logic [LANES-1:0]              abort_pulse,
    output logic [$clog2(CAPACITY+1)-1:0] count,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow_err,
    output logic                          underflow_err
);

    localparam int CW = $clog2(CAPACITY + 1);
    // Headroom for count plus up to 8 simultaneous events of either sign
    localparam int SW = CW + 5;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_detector #(
            .DEBOUNCE (DEBOUNCE),
            .TIMEOUT  (TIMEOUT)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .sd1         (sd1[g]),
            .sd2         (sd2[g]),
            .enter_pulse (enter_pulse[g]),
            .exit_pulse  (exit_pulse[g]),
            .abort_pulse (abort_pulse[g])
        );
    end

    function automatic logic signed [SW-1:0] popcount(input logic [LANES-1:0] v);
        logic signed [SW-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++)
            if (v[i]) n = n + SW'(1);
        return n;
    endfunction

    function automatic logic [CW-1:0] sat_count(input logic signed [SW-1:0] v);
        if (v < 0)
            return '0;
        else if (v > SW'(CAPACITY))
            return CW'(CAPACITY);
        else
            return v[CW-1:0];
    endfunction

    logic signed [SW-1:0] cnt_ext, sum;

    assign cnt_ext = signed'(SW'(count));
    assign sum     = cnt_ext + popcount(enter_pulse) - popcount(exit_pulse);

    // Stage p3: occupancy counter and sticky errors from registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            count <= sat_count(sum);
            if (sum > SW'(CAPACITY)) overflow_err  <= 1'b1;
            if (sum < 0)             underflow_err <= 1'b1;
        end
    end

    assign full  = (count == CW'(CAPACITY));
    assign empty = (count == '0);

endmodule

// File: tb/tb_parking_lane_monitor.sv
// Directed bench for parking_lane_monitor: table of sensor steps with
// expected pulses/count/flags, plus hand sequences for timing corners.
module tb_parking_lane_monitor;
    import parking_pkg::*;

    localparam int LANES    = 2;
    localparam int CAPACITY = 64;
    localparam int DEBOUNCE = 4;
    localparam int TIMEOUT  = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sd1 = 2'b11;
    logic [1:0] sd2 = 2'b11;
    logic [1:0] enter_pulse, exit_pulse, abort_pulse;
    logic [6:0] count;
    logic       full, empty, overflow_err, underflow_err;

    parking_lane_monitor #(
        .LANES(LANES), .CAPACITY(CAPACITY), .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sd1           (sd1),
        .sd2           (sd2),
        .enter_pulse   (enter_pulse),
        .exit_pulse    (exit_pulse),
        .abort_pulse   (abort_pulse),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int en_cnt [2];
    int ex_cnt [2];
    int ab_cnt [2];
    int cnt_min, cnt_max, simul;

    typedef struct {
        logic [1:0] sd1;
        logic [1:0] sd2;
        int         en;     // lane1*16 + lane0 pulse totals
        int         ex;
        int         ab;
        int         cnt;
        logic [3:0] flags;  // {full, empty, overflow_err, underflow_err}
    } step_t;

    step_t tbl [16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_stats();
        for (int l = 0; l < 2; l++) begin
            en_cnt[l] = 0; ex_cnt[l] = 0; ab_cnt[l] = 0;
        end
        cnt_min = 1000; cnt_max = -1; simul = 0;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (enter_pulse[l]) en_cnt[l]++;
                if (exit_pulse[l])  ex_cnt[l]++;
                if (abort_pulse[l]) ab_cnt[l]++;
            end
            if (enter_pulse[0] && exit_pulse[1]) simul++;
            if (int'(count) < cnt_min) cnt_min = int'(count);
            if (int'(count) > cnt_max) cnt_max = int'(count);
        end
    endtask

    function automatic int enc(input int a1, input int a0);
        return a1 * 16 + a0;
    endfunction

    function automatic int flags_now();
        return int'({full, empty, overflow_err, underflow_err});
    endfunction

    task automatic drive(input logic [1:0] s1, input logic [1:0] s2, input int n);
        sd1 = s1;
        sd2 = s2;
        tick(n);
    endtask

    task automatic entry_seq(input logic [1:0] m);
        drive(~m, 2'b11, 10);
        drive(~m, ~m, 10);
        drive(2'b11, ~m, 10);
        drive(2'b11, 2'b11, 10);
    endtask

    task automatic exit_seq(input logic [1:0] m);
        drive(2'b11, ~m, 10);
        drive(~m, ~m, 10);
        drive(~m, 2'b11, 10);
        drive(2'b11, 2'b11, 10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sd1 = 2'b11;
        sd2 = 2'b11;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        int first, width, c7, c8, c0;

        tbl[0]  = '{2'b10, 2'b11, 0,    0,    0, 0, 4'b0100};
        tbl[1]  = '{2'b10, 2'b10, 0,    0,    0, 0, 4'b0100};
        tbl[2]  = '{2'b11, 2'b10, 0,    0,    0, 0, 4'b0100};
        tbl[3]  = '{2'b11, 2'b11, 'h01, 0,    0, 1, 4'b0000};
        tbl[4]  = '{2'b10, 2'b11, 0,    0,    0, 1, 4'b0000};
        tbl[5]  = '{2'b10, 2'b10, 0,    0,    0, 1, 4'b0000};
        tbl[6]  = '{2'b10, 2'b11, 0,    0,    0, 1, 4'b0000};
        tbl[7]  = '{2'b11, 2'b11, 0,    0,    0, 1, 4'b0000};
        tbl[8]  = '{2'b11, 2'b01, 0,    0,    0, 1, 4'b0000};
        tbl[9]  = '{2'b01, 2'b01, 0,    0,    0, 1, 4'b0000};
        tbl[10] = '{2'b01, 2'b11, 0,    0,    0, 1, 4'b0000};
        tbl[11] = '{2'b11, 2'b11, 0,    'h10, 0, 0, 4'b0100};
        tbl[12] = '{2'b11, 2'b01, 0,    0,    0, 0, 4'b0100};
        tbl[13] = '{2'b01, 2'b01, 0,    0,    0, 0, 4'b0100};
        tbl[14] = '{2'b01, 2'b11, 0,    0,    0, 0, 4'b0100};
        tbl[15] = '{2'b11, 2'b11, 0,    'h10, 0, 0, 4'b0101};

        clr_stats();
        rst = 1'b1;
        tick(3);
        check("rst_pulses", int'({enter_pulse, exit_pulse, abort_pulse}), 0);
        check("rst_count", int'(count), 0);
        check("rst_flags", flags_now(), 4'b0100);
        rst = 1'b0;
        tick(1);
        check("post_rst_flags", flags_now(), 4'b0100);

        // Table: entry, reversal back-out, exit, exit at empty
        for (int s = 0; s < 16; s++) begin
            clr_stats();
            drive(tbl[s].sd1, tbl[s].sd2, 10);
            check($sformatf("step%0d_enter", s), enc(en_cnt[1], en_cnt[0]), tbl[s].en);
            check($sformatf("step%0d_exit", s),  enc(ex_cnt[1], ex_cnt[0]), tbl[s].ex);
            check($sformatf("step%0d_abort", s), enc(ab_cnt[1], ab_cnt[0]), tbl[s].ab);
            check($sformatf("step%0d_count", s), int'(count), tbl[s].cnt);
            check($sformatf("step%0d_flags", s), flags_now(), int'(tbl[s].flags));
        end

        // 3-cycle glitch on lane 0 outer sensor must be filtered
        clr_stats();
        drive(2'b10, 2'b11, 3);
        drive(2'b11, 2'b11, 15);
        check("glitch_pulses", enc(en_cnt[1], en_cnt[0]) + enc(ex_cnt[1], ex_cnt[0])
              + enc(ab_cnt[1], ab_cnt[0]), 0);
        check("glitch_state_idle", int'(dut.g_lane[0].u_lane.state == IDLE), 1);

        // Exact latency of a lane 1 entry: pulse 7 cycles after the raw release
        clr_stats();
        drive(2'b01, 2'b11, 10);
        drive(2'b01, 2'b01, 10);
        drive(2'b11, 2'b01, 10);
        sd1 = 2'b11;
        sd2 = 2'b11;
        first = 0; width = 0; c7 = -1; c8 = -1; c0 = int'(count);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (enter_pulse[1]) begin
                if (first == 0) first = i;
                width++;
            end
            if (i == 7) c7 = int'(count);
            if (i == 8) c8 = int'(count);
        end
        check("lat_first_pulse", first, 2 + DEBOUNCE + 1);
        check("lat_pulse_width", width, 1);
        check("lat_count_same_cycle", c7, c0);
        check("lat_count_next_cycle", c8, c0 + 1);

        // Lane 1 inner sensor stuck blocked: one abort, count unchanged
        clr_stats();
        c0 = int'(count);
        drive(2'b11, 2'b01, TIMEOUT + 10);
        drive(2'b11, 2'b11, 20);
        check("timeout_abort", enc(ab_cnt[1], ab_cnt[0]), 'h10);
        check("timeout_no_evt", enc(en_cnt[1], en_cnt[0]) + enc(ex_cnt[1], ex_cnt[0]), 0);
        check("timeout_count", int'(count), c0);

        // Fill to capacity, then overflow with simultaneous entries
        do_reset();
        check("reset_clears_unf", int'(underflow_err), 0);
        for (int r = 0; r < CAPACITY / 2; r++) entry_seq(2'b11);
        check("cap_count", int'(count), CAPACITY);
        check("cap_flags", flags_now(), 4'b1000);
        entry_seq(2'b11);
        check("ovf_count", int'(count), CAPACITY);
        check("ovf_flags", flags_now(), 4'b1010);
        exit_seq(2'b01);
        check("ovf_sticky_count", int'(count), CAPACITY - 1);
        check("ovf_sticky_flags", flags_now(), 4'b0010);
        do_reset();
        check("ovf_cleared_flags", flags_now(), 4'b0100);

        // count=5, entry on lane 0 and exit on lane 1 complete together
        entry_seq(2'b11);
        entry_seq(2'b11);
        entry_seq(2'b01);
        check("five_count", int'(count), 5);
        clr_stats();
        drive(2'b10, 2'b01, 10);
        drive(2'b00, 2'b00, 10);
        drive(2'b01, 2'b10, 10);
        drive(2'b11, 2'b11, 10);
        check("simul_same_cycle", simul, 1);
        check("simul_enter", enc(en_cnt[1], en_cnt[0]), 'h01);
        check("simul_exit", enc(ex_cnt[1], ex_cnt[0]), 'h10);
        check("simul_count_min", cnt_min, 5);
        check("simul_count_max", cnt_max, 5);
        check("simul_flags", flags_now(), 4'b0000);

        // Reset in the middle of EN2
        drive(2'b10, 2'b11, 10);
        drive(2'b10, 2'b10, 10);
        check("en2_reached", int'(dut.g_lane[0].u_lane.state == EN2), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pulses", int'({enter_pulse, exit_pulse, abort_pulse}), 0);
        check("midrst_count", int'(count), 0);
        check("midrst_flags", flags_now(), 4'b0100);
        check("midrst_state_idle", int'(dut.g_lane[0].u_lane.state == IDLE), 1);
        rst = 1'b0;
        clr_stats();
        drive(2'b10, 2'b10, 10);
        drive(2'b11, 2'b11, 20);
        check("midrst_no_pulse", enc(en_cnt[1], en_cnt[0]) + enc(ex_cnt[1], ex_cnt[0])
              + enc(ab_cnt[1], ab_cnt[0]), 0);
        check("midrst_count_after", int'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parking_lane_monitor.md
# parking_lane_monitor

Multi-lane successor to the single-gate car detector. Monitors LANES gates, each with an outer sensor (sd1) and an inner sensor (sd2), both active-low. Each lane synchronises and debounces its sensors, tracks entry/exit sequences with reversal and timeout handling, and emits per-lane event pulses. A shared saturating occupancy counter with full/empty flags and sticky error flags feeds the lot display and gate controller.

## Interface
- LANES, 2, number of monitored gates (1..8)
- CAPACITY, 64, lot capacity; count saturates here
- DEBOUNCE, 4, cycles a synchronised sensor level must be stable before it is accepted (≥1)
- TIMEOUT, 1024, cycles a lane may remain in one non-idle state before aborting (≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sd1  in  LANES  outer sensors, raw asynchronous, 0 = blocked
- sd2  in  LANES  inner sensors, raw asynchronous, 0 = blocked
- enter_pulse  out  LANES  one-cycle pulse per completed entry
- exit_pulse  out  LANES  one-cycle pulse per completed exit
- abort_pulse  out  LANES  one-cycle pulse when a lane times out
- count  out  $clog2(CAPACITY+1)  current occupancy
- full  out  1  count == CAPACITY
- empty  out  1  count == 0
- overflow_err  out  1  sticky; an entry was dropped at full
- underflow_err  out  1  sticky; an exit was dropped at empty

## Operation
- Per lane: 2-flop synchroniser on each sensor, then a debounce counter. Accepted level changes only after DEBOUNCE consecutive equal synchronised samples. Accepted levels reset to 1 (clear).
- Lane FSM, with b1/b2 the accepted blocked flags:
  - IDLE: b1&!b2 -> EN1; else !b1&b2 -> EX1; both blocked or both clear -> stay.
  - EN1 (b1 only): b1&b2 -> EN2; both clear -> IDLE.
  - EN2 (both blocked): !b1&b2 -> EN3; b1&!b2 -> EN1 (reversal).
  - EN3 (b2 only): both clear -> IDLE and enter_pulse; b1&b2 -> EN2 (reversal).
  - EX1/EX2/EX3 mirror these with b1 and b2 swapped; completion asserts exit_pulse.
  - Any other input combination holds the state.
- Timeout: per-lane timer clears on every state change. In a non-idle state, reaching TIMEOUT-1 forces IDLE and asserts abort_pulse. No count change.
- Counter: net = popcount(enter_pulse) − popcount(exit_pulse), computed from the registered pulses.
  - new = clamp(count + net, 0, CAPACITY).
  - If the unclamped value exceeds CAPACITY, set overflow_err. If it is below 0, set underflow_err.
  - Simultaneous entries and exits in different lanes net out before clamping.
- rst mid-sequence: all lanes return to IDLE, synchronisers and debouncers return to the clear state, and no pulse is emitted.

## Timing
- Reset values:
  - pulses 0, count 0, full 0, empty 1, both err 0.
  - FSMs IDLE, timers 0, accepted sensor levels 1.
- Raw sensor edge to FSM seeing the accepted level: 2 + DEBOUNCE cycles.
- FSM completion transition at edge E: pulse is high for exactly the cycle after E. count, full, empty and err flags update at edge E+1.
- Pulses are registered and never combinational from inputs.
- Per lane, at most one pulse per cycle, and at most one completion per 4 accepted sensor transitions.

## Structure
- Package parking_pkg: lane_state_t (one-hot enum IDLE, EN1–EN3, EX1–EX3) and the sensor-encoding constants BLOCKED = 1'b0, CLEAR = 1'b1.
- Sub-module lane_detector: synchroniser, debounce, FSM and timeout for one lane. Instantiated LANES times via generate.
- The top level holds the popcount, the saturating counter and the flags.

## Test plan
- LANES=2, DEBOUNCE=4. Lane 0 runs sd1 low, both low, sd1 high, sd2 high, each held 10 cycles -> one enter_pulse[0], count 0->1, empty falls.
- Lane 0 reversal: EN1 -> EN2 -> EN1 -> IDLE (car backs out) -> no pulse, count unchanged.
- 3-cycle glitch on sd1 with DEBOUNCE=4 -> FSM stays IDLE, no pulse.
- Lane 1 blocks sd2 only for TIMEOUT+10 cycles -> abort_pulse[1] once, count unchanged.
- count=CAPACITY and simultaneous entries on lanes 0 and 1 -> count stays CAPACITY, overflow_err set and held until rst.
- count=5, entry on lane 0 completes in the same cycle as an exit on lane 1 -> count stays 5, no error. Assert rst mid-EN2 -> all outputs return to reset values next cycle.
